// File: rtl/pfa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pfa_pkg
// Purpose  : Shared constants and types for the pfa_adder ripple-carry adder.
//            - PFA_DEFAULT_SIZE : default operand/sum width
//            - pfa_result_t     : sum/carry pair, sized for the widest legal
//                                 configuration (64 bits)
// Revision : 1.0 - initial release
// ============================================================================
package pfa_pkg;

    localparam int PFA_DEFAULT_SIZE = 16;
    localparam int PFA_MAX_SIZE     = 64;

    typedef struct packed {
        logic [PFA_MAX_SIZE-1:0] sum;
        logic                    carry;
    } pfa_result_t;

endpackage : pfa_pkg
`default_nettype wire

// File: rtl/pfa_fa_cell.sv
`default_nettype none
// ============================================================================
// Module   : pfa_fa_cell
// Purpose  : One-bit full adder, purely combinational. One link of the
//            ripple chain inside pfa_adder.
// Ports    : a, b  - operand bits
//            ci    - carry in from the next-lower bit
//            s     - sum bit
//            co    - carry out to the next-higher bit
// Revision : 1.0 - initial release
// ============================================================================
module pfa_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_p;

    // Propagate term is shared between the sum and the carry.
    assign w_p = a ^ b;
    assign s   = w_p ^ ci;
    assign co  = (a & b) | (w_p & ci);

endmodule : pfa_fa_cell
`default_nettype wire

// File: rtl/pfa_adder.sv
`default_nettype none
// ============================================================================
// Module   : pfa_adder
// Purpose  : SIZE-bit ripple-carry adder with a single output register stage.
//            {c_out, s} = a + b + c_in, latency exactly one cycle, accepts a
//            new operand pair every cycle.
// Ports    : clk       - rising-edge clock
//            rst_n     - asynchronous active-low reset
//            in_valid  - operands valid this cycle
//            a, b      - SIZE-bit unsigned operands
//            c_in      - carry in
//            s         - registered sum (low SIZE bits)
//            c_out     - registered carry out (bit SIZE)
//            out_valid - s/c_out hold a new result
//            ovf       - registered two's-complement overflow
//                        (present only when PFA_OVF_EN is defined)
// Config   : PFA_OVF_EN - adds the ovf output
// Params   : SIZE - operand/sum width, 1..64
// Revision : 1.0 - initial release
// ============================================================================
module pfa_adder
    import pfa_pkg::*;
#(
    parameter int SIZE = PFA_DEFAULT_SIZE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            c_in,
    output logic [SIZE-1:0] s,
    output logic            c_out,
    output logic            out_valid
`ifdef PFA_OVF_EN
    ,
    output logic            ovf
`endif
);

    // ------------------------------------------------------------------
    // Ripple chain: w_carry[i] is the carry into bit i, so w_carry[0] is
    // c_in and w_carry[SIZE] is the final carry out.
    // ------------------------------------------------------------------
    logic [SIZE-1:0] w_sum;
    logic [SIZE:0]   w_carry;

    assign w_carry[0] = c_in;

    generate
        for (genvar gi = 0; gi < SIZE; gi++) begin : g_cell
            pfa_fa_cell u_cell (
                .a  (a[gi]),
                .b  (b[gi]),
                .ci (w_carry[gi]),
                .s  (w_sum[gi]),
                .co (w_carry[gi+1])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output register. Result registers load only on accepted inputs and
    // otherwise hold; the valid flag tracks in_valid every cycle.
    // ------------------------------------------------------------------
    logic [SIZE-1:0] r_sum;
    logic            r_cout;
    logic            r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_carry[SIZE];
            end
        end
    end

    assign s         = r_sum;
    assign c_out     = r_cout;
    assign out_valid = r_valid;

`ifdef PFA_OVF_EN
    // Signed overflow: the carry into the MSB disagrees with the carry out.
    logic w_ovf;
    logic r_ovf;

    assign w_ovf = w_carry[SIZE-1] ^ w_carry[SIZE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (in_valid) begin
            r_ovf <= w_ovf;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule : pfa_adder
`default_nettype wire

// File: tb/tb_pfa_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pfa_adder
// Purpose  : Self-checking bench for pfa_adder (SIZE=16). Table-driven
//            vectors plus hand-written reset / hold sequences; expected
//            results are queued when stimulus is driven and popped when the
//            DUT signals out_valid. Define PFA_OVF_EN to exercise ovf.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pfa_adder;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic [W-1:0] s;
    logic         c_out;
    logic         out_valid;
    logic         ovf;

    pfa_adder #(.SIZE(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .s         (s),
        .c_out     (c_out),
        .out_valid (out_valid)
`ifdef PFA_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

`ifndef PFA_OVF_EN
    assign ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    exp_t sb[$];
    exp_t held;
    int   n_vec;
    int   n_miss;

    // Independent reference: full-width add, overflow from operand/result signs.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                   input logic tc);
        logic [W:0] full;
        exp_t       r;
        full = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
        r.s  = full[W-1:0];
        r.co = full[W];
        r.ov = (ta[W-1] == tb[W-1]) && (full[W-1] != ta[W-1]);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".s"},     64'(s),     64'(held.s));
        check({tag, ".c_out"}, 64'(c_out), 64'(held.co));
`ifdef PFA_OVF_EN
        check({tag, ".ovf"},   64'(ovf),   64'(held.ov));
`endif
    endtask

    // One clock: drive at the falling edge, sample 1 ns after the rising edge.
    task automatic step(input string tag, input logic v, input logic [W-1:0] ta,
                        input logic [W-1:0] tb, input logic tc);
        logic accepted;
        @(negedge clk);
        in_valid = v;
        a        = ta;
        b        = tb;
        c_in     = tc;
        accepted = v && rst_n;
        if (accepted) sb.push_back(model(ta, tb, tc));
        @(posedge clk);
        #1;
        check({tag, ".out_valid"}, 64'(out_valid), 64'(accepted));
        if (out_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL %s.scoreboard: out_valid with no pending result", tag);
            end else begin
                held = sb.pop_front();
            end
        end
        check_outputs(tag);
    endtask

    vec_t tbl[7];

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        held     = '0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        c_in     = 1'b1;

        tbl[0] = '{a:16'd10000, b:16'd50000, ci:1'b1, s:16'd60001, co:1'b0, ov:1'b0};
        tbl[1] = '{a:16'hFFFF,  b:16'h0000,  ci:1'b1, s:16'h0000,  co:1'b1, ov:1'b0};
        tbl[2] = '{a:16'd50000, b:16'd34464, ci:1'b0, s:16'd18928, co:1'b1, ov:1'b1};
        tbl[3] = '{a:16'h7FFF,  b:16'h0001,  ci:1'b0, s:16'h8000,  co:1'b0, ov:1'b1};
        tbl[4] = '{a:16'h8000,  b:16'h8000,  ci:1'b0, s:16'h0000,  co:1'b1, ov:1'b1};
        tbl[5] = '{a:16'h0000,  b:16'h0000,  ci:1'b0, s:16'h0000,  co:1'b0, ov:1'b0};
        tbl[6] = '{a:16'hFFFF,  b:16'hFFFF,  ci:1'b1, s:16'hFFFF,  co:1'b1, ov:1'b0};

        // Reset state, before any clock edge, with operands present.
        #2;
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check_outputs("reset");

        // Operand present across an edge in reset must be discarded.
        @(posedge clk);
        #1;
        check("reset_edge.out_valid", 64'(out_valid), 64'd0);
        check_outputs("reset_edge");

        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;

        // Table: constants, applied back-to-back, each checked against its
        // hand-computed expectation in addition to the scoreboard.
        for (int i = 0; i < 7; i++) begin
            step($sformatf("tbl%0d", i), 1'b1, tbl[i].a, tbl[i].b, tbl[i].ci);
            check($sformatf("tbl%0d.s_const", i),  64'(s),     64'(tbl[i].s));
            check($sformatf("tbl%0d.co_const", i), 64'(c_out), 64'(tbl[i].co));
`ifdef PFA_OVF_EN
            check($sformatf("tbl%0d.ov_const", i), 64'(ovf),   64'(tbl[i].ov));
`endif
        end

        // Hold: one accepted vector, then three idle cycles with changing junk.
        step("hold_load", 1'b1, 16'h1234, 16'h0100, 1'b1);
        check("hold_load.s_const", 64'(s), 64'h1335);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("hold%0d", i), 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
            check($sformatf("hold%0d.s_const", i), 64'(s), 64'h1335);
        end

        // Mid-stream asynchronous reset between clock edges.
        step("pre_rst", 1'b1, 16'hFFFF, 16'h0001, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        held = '0;
        check("async_rst.out_valid", 64'(out_valid), 64'd0);
        check_outputs("async_rst");
        step("in_rst", 1'b1, 16'h4321, 16'h1111, 1'b1);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step("post_rst_idle", 1'b0, 16'h0000, 16'h0000, 1'b0);
        step("post_rst_first", 1'b1, 16'h0102, 16'h0304, 1'b1);
        check("post_rst_first.s_const", 64'(s), 64'h0407);

        // Random back-to-back vectors against the behavioural model, with
        // occasional bubbles.
        for (int i = 0; i < 20; i++) begin
            step($sformatf("rnd%0d", i), 1'($urandom_range(0, 3) != 0),
                 16'($urandom), 16'($urandom), 1'($urandom));
        end
        step("drain", 1'b0, 16'h0000, 16'h0000, 1'b0);

        n_vec++;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_empty: got %0d pending, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_pfa_adder
`default_nettype wire

// File: doc/pfa_adder.md
PFA_ADDER -- requirements
Module: pfa_adder

Interface
REQ-001 SHALL have parameter SIZE, default 16, operand/sum width in bits; legal range 1..64.
REQ-002 SHALL have port clk  input  1  rising-edge clock; one clock only.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  operands valid this cycle.
REQ-005 SHALL have port a  input  SIZE  unsigned operand A.
REQ-006 SHALL have port b  input  SIZE  unsigned operand B.
REQ-007 SHALL have port c_in  input  1  carry in.
REQ-008 SHALL have port s  output  SIZE  registered sum, the low SIZE bits of a+b+c_in.
REQ-009 SHALL have port c_out  output  1  registered carry out, bit SIZE of a+b+c_in.
REQ-010 SHALL have port out_valid  output  1  s/c_out hold a new result.

Function
REQ-011 SHALL compute {c_out,s} = a + b + c_in at full SIZE+1 width, with no saturation.
REQ-012 SHALL build the sum as a ripple chain of SIZE one-bit full-adder cells: bit 0 takes c_in, bit i takes the carry of bit i-1, and c_out is the carry of bit SIZE-1.
REQ-013 SHALL register s and c_out on the rising clk edge when in_valid=1, giving a latency of exactly 1 cycle.
REQ-014 SHALL hold s and c_out at their previous values when in_valid=0.
REQ-015 SHALL set out_valid to in_valid, registered every cycle; out_valid is high for exactly the cycles following accepted inputs.
REQ-016 SHALL accept back-to-back operands every cycle, with no stall and no backpressure.
REQ-017 SHALL wrap modulo 2^SIZE: all-ones + 0 + c_in=1 gives s=0, c_out=1.
REQ-018 SHALL treat X/Z-free inputs only; the output has no dependence on prior results.

Reset
REQ-019 SHALL on rst_n=0 immediately drive s=0, c_out=0 and out_valid=0, independent of clk.
REQ-020 SHALL discard any operand presented during reset or at the edge where rst_n is low.
REQ-021 SHALL accept the first operand on the first rising edge with rst_n=1; its result is visible one cycle later.

Configuration
REQ-022 SHALL provide macro PFA_OVF_EN; when defined, the module adds output ovf (1 bit, registered alongside s) equal to two's-complement signed overflow: carry into the MSB XOR c_out.
REQ-023 SHALL reset ovf to 0 and hold it under the same rules as s.
REQ-024 SHALL, without PFA_OVF_EN, omit the ovf port entirely; the remaining behaviour is identical.

Structure
REQ-025 SHALL place the default width constant PFA_DEFAULT_SIZE=16 and a result struct type (sum, carry) in shared package pfa_pkg.
REQ-026 SHALL implement the one-bit cell as sub-module pfa_fa_cell (a, b, ci -> s, co), instantiated SIZE times through a generate loop.
REQ-027 SHALL keep all sequential logic in pfa_adder; pfa_fa_cell is purely combinational.

Verification
REQ-028 SHALL cover: SIZE=16, a=10000, b=50000, c_in=1, in_valid=1 -> next cycle s=60001, c_out=0, out_valid=1.
REQ-029 SHALL cover: a=0xFFFF, b=0x0000, c_in=1 -> s=0x0000, c_out=1 (wrap boundary).
REQ-030 SHALL cover: a=50000, b=34464, c_in=0 -> s=18928, c_out=1.
REQ-031 SHALL cover: a=0x1234 accepted, then in_valid=0 for 3 cycles -> s holds 0x1234+b+c_in and out_valid=0.
REQ-032 SHALL cover: rst_n driven low mid-stream between clock edges -> s=0, c_out=0, out_valid=0 immediately; after release the first result appears 1 cycle after the first valid input.
REQ-033 SHALL cover: with PFA_OVF_EN, a=0x7FFF, b=0x0001, c_in=0 -> s=0x8000, ovf=1, c_out=0; then 20 random vectors checked against a behavioural SIZE+1-bit model.
